// File: rtl/sdio_crc_lanes.sv
// N-lane bit-serial CRC engine for the SDIO CMD/DAT lines. Each lane runs its own LFSR,
// and the engine can shift the result out serially or compare it against incoming data.
module sdio_crc_lanes #(
    parameter int unsigned          CRC_W   = 16,
    parameter logic [CRC_W-1:0]     POLY    = 16'h1021,
    parameter int unsigned          N_LANES = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic [N_LANES-1:0]         data_i,
    input  logic                       out_start_i,
    input  logic                       chk_start_i,
    output logic [N_LANES*CRC_W-1:0]   crc_o,
    output logic [N_LANES-1:0]         serial_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [N_LANES-1:0]         err_o
);

    localparam int unsigned CntW = $clog2(CRC_W);

    typedef enum logic [1:0] {StAcc, StOut, StChk} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q [N_LANES];
    logic [CRC_W-1:0]   crc_d [N_LANES];
    logic [N_LANES-1:0] err_q, err_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            crc_d[l] = crc_q[l];
        end

        if (clr_i) begin
            state_d = StAcc;
            cnt_d   = '0;
            err_d   = '0;
            for (int l = 0; l < N_LANES; l++) begin
                crc_d[l] = '0;
            end
        end else begin
            case (state_q)
                StAcc: begin
                    // A start claims the cycle; the strobe in that cycle is not accumulated.
                    if (out_start_i) begin
                        state_d = StOut;
                        cnt_d   = '0;
                    end else if (chk_start_i) begin
                        state_d = StChk;
                        cnt_d   = '0;
                        err_d   = '0;
                    end else if (en_i) begin
                        for (int l = 0; l < N_LANES; l++) begin
                            crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0}
                                     ^ ((data_i[l] ^ crc_q[l][CRC_W-1]) ? POLY : '0);
                        end
                    end
                end
                StOut, StChk: begin
                    if (en_i) begin
                        for (int l = 0; l < N_LANES; l++) begin
                            if (state_q == StChk) begin
                                err_d[l] = err_q[l] | (data_i[l] ^ crc_q[l][CRC_W-1]);
                            end
                            crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0};
                        end
                        if (cnt_q == CntW'(CRC_W - 1)) begin
                            state_d = StAcc;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StAcc;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StAcc;
            cnt_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            for (int l = 0; l < N_LANES; l++) begin
                crc_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            for (int l = 0; l < N_LANES; l++) begin
                crc_q[l] <= crc_d[l];
            end
        end
    end

    always_comb begin
        crc_o    = '0;
        serial_o = '0;
        for (int l = 0; l < N_LANES; l++) begin
            crc_o[l*CRC_W +: CRC_W] = crc_q[l];
            serial_o[l]             = crc_q[l][CRC_W-1];
        end
    end

    assign busy_o = (state_q != StAcc);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_sdio_crc_lanes.sv
// Directed bench: a 1-lane CRC7 instance and a default 4-lane CRC16 instance share the clock;
// known SD command CRCs and CRC-16/XMODEM values provide the expected results.
module tb_sdio_crc_lanes;

    logic clk;
    logic rstn;

    logic        a_clr, a_en, a_os, a_cs;
    logic [0:0]  a_data, a_ser, a_err;
    logic [6:0]  a_crc;
    logic        a_busy, a_done;

    logic        b_clr, b_en, b_os, b_cs;
    logic [3:0]  b_data, b_ser, b_err;
    logic [63:0] b_crc;
    logic        b_busy, b_done;

    int n_assert = 0;
    int n_fail   = 0;

    sdio_crc_lanes #(.CRC_W(7), .POLY(7'h09), .N_LANES(1)) u_cmd (
        .clk_i(clk), .rstn_i(rstn), .clr_i(a_clr), .en_i(a_en), .data_i(a_data),
        .out_start_i(a_os), .chk_start_i(a_cs), .crc_o(a_crc), .serial_o(a_ser),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
    );

    sdio_crc_lanes u_dat (
        .clk_i(clk), .rstn_i(rstn), .clr_i(b_clr), .en_i(b_en), .data_i(b_data),
        .out_start_i(b_os), .chk_start_i(b_cs), .crc_o(b_crc), .serial_o(b_ser),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] msg;
        logic [6:0]  crc;
    } cmd_vec_t;

    typedef struct {
        logic [3:0][71:0] dat;
        logic [3:0][15:0] crc;
    } lane_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic a_step(input logic en, input logic d, input logic os, input logic cs,
                          input logic clr);
        a_en = en; a_data = d; a_os = os; a_cs = cs; a_clr = clr;
        @(posedge clk);
        #1;
        a_en = 0; a_data = 0; a_os = 0; a_cs = 0; a_clr = 0;
    endtask

    task automatic b_step(input logic en, input logic [3:0] d, input logic os, input logic cs,
                          input logic clr);
        b_en = en; b_data = d; b_os = os; b_cs = cs; b_clr = clr;
        @(posedge clk);
        #1;
        b_en = 0; b_data = 0; b_os = 0; b_cs = 0; b_clr = 0;
    endtask

    task automatic b_feed_byte(input logic [7:0] byt);
        for (int i = 7; i >= 0; i--) b_step(1, {4{byt[i]}}, 0, 0, 0);
    endtask

    cmd_vec_t  cmd_tab [4];
    lane_vec_t lane_tab[2];

    initial begin
        logic [15:0] w;
        logic [3:0]  d;
        int          n;
        int          cyc;

        cmd_tab[0] = '{msg: 40'h5100000000, crc: 7'h2A};
        cmd_tab[1] = '{msg: 40'h48000001AA, crc: 7'h43};
        cmd_tab[2] = '{msg: 40'h7700000000, crc: 7'h32};
        cmd_tab[3] = '{msg: 40'h4000000000, crc: 7'h4A};

        lane_tab[0].dat = {72'h0, 72'h01, 72'h41, 72'h313233343536373839};
        lane_tab[0].crc = {16'h0000, 16'h1021, 16'h58E5, 16'h31C3};
        lane_tab[1].dat = {72'h41, 72'h313233343536373839, 72'h01, 72'h0};
        lane_tab[1].crc = {16'h58E5, 16'h31C3, 16'h1021, 16'h0000};

        a_clr = 0; a_en = 0; a_data = 0; a_os = 0; a_cs = 0;
        b_clr = 0; b_en = 0; b_data = 0; b_os = 0; b_cs = 0;
        rstn = 1'b0;
        #22 rstn = 1'b1;
        @(posedge clk);
        #1;

        check("rst_a_crc", a_crc, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_crc", b_crc, 0);
        check("rst_b_flags", {b_busy, b_done, b_err}, 0);

        // CRC7 command table; CMD0 last so the OUT test follows from it
        for (int t = 0; t < 4; t++) begin
            a_step(0, 0, 0, 0, 1);
            for (int i = 39; i >= 0; i--) a_step(1, cmd_tab[t].msg[i], 0, 0, 0);
            check($sformatf("cmd_crc7[%0d]", t), a_crc, cmd_tab[t].crc);
        end

        // Serial emit of CMD0's CRC7 (7'h4A = 1001010)
        w = 16'h004A;
        a_step(0, 0, 1, 0, 0);
        check("a_out_busy", a_busy, 1);
        for (int i = 6; i >= 0; i--) begin
            check($sformatf("a_ser[%0d]", i), a_ser, w[i]);
            if (i == 0) check("a_done_early", a_done, 0);
            a_step(1, 0, 0, 0, 0);
        end
        check("a_done", a_done, 1);
        check("a_idle", a_busy, 0);
        check("a_crc_zero", a_crc, 0);
        a_step(0, 0, 0, 0, 0);
        check("a_done_pulse", a_done, 0);

        // CRC16 four-lane table
        for (int t = 0; t < 2; t++) begin
            b_step(0, 0, 0, 0, 1);
            for (int i = 71; i >= 0; i--)
                b_step(1, {lane_tab[t].dat[3][i], lane_tab[t].dat[2][i],
                           lane_tab[t].dat[1][i], lane_tab[t].dat[0][i]}, 0, 0, 0);
            check($sformatf("lane_crc16[%0d]", t), b_crc, lane_tab[t].crc);
        end

        // 4096 ones per lane, back to back then with random strobe gaps
        b_step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4096; i++) b_step(1, 4'hF, 0, 0, 0);
        check("ones_crc", b_crc, 64'h7FA17FA17FA17FA1);
        b_step(0, 0, 0, 0, 1);
        n = 0;
        cyc = 0;
        while (n < 4096 && cyc < 20000) begin
            if ($urandom_range(0, 1) == 1) begin
                b_step(1, 4'hF, 0, 0, 0);
                n++;
            end else begin
                b_step(0, 4'h0, 0, 0, 0);
            end
            cyc++;
        end
        check("gap_strobes", n, 4096);
        check("gap_crc", b_crc, 64'h7FA17FA17FA17FA1);

        // Compare mode: lane 2 gets CRC bit 5 inverted
        w = 16'h7FA1;
        b_step(0, 0, 0, 1, 0);
        check("chk_busy", b_busy, 1);
        for (int i = 15; i >= 0; i--) begin
            d = {4{w[i]}};
            if (i == 5) d[2] = ~d[2];
            if (i == 0) check("chk_done_early", b_done, 0);
            b_step(1, d, 0, 0, 0);
        end
        check("chk_done", b_done, 1);
        check("chk_err", b_err, 4'b0100);
        check("chk_crc_zero", b_crc, 0);
        b_step(0, 0, 0, 0, 0);
        check("chk_err_hold", b_err, 4'b0100);
        b_step(0, 0, 0, 0, 1);
        check("clr_err", b_err, 0);

        // Abort OUT after 3 strobes
        b_feed_byte(8'h41);
        check("byte_crc", b_crc, 64'h58E558E558E558E5);
        b_step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) b_step(1, 0, 0, 0, 0);
        check("out3_crc", b_crc, 64'hC728C728C728C728);
        b_step(0, 0, 0, 0, 1);
        check("abort_busy", b_busy, 0);
        check("abort_crc", b_crc, 0);
        check("abort_done", b_done, 0);
        b_step(1, 0, 0, 0, 0);
        check("abort_no_done", b_done, 0);

        // Both starts together enter OUT: no error accumulates on mismatching data
        b_step(0, 0, 0, 0, 1);
        b_feed_byte(8'h41);
        w = 16'h58E5;
        b_step(1, 4'hF, 1, 1, 0);
        check("both_busy", b_busy, 1);
        check("both_crc_hold", b_crc, 64'h58E558E558E558E5);
        for (int i = 15; i >= 0; i--) begin
            check($sformatf("both_ser[%0d]", i), b_ser, {4{w[i]}});
            b_step(1, 4'hF, 0, 0, 0);
        end
        check("both_done", b_done, 1);
        check("both_err", b_err, 0);

        // Asynchronous reset in the middle of a compare
        b_feed_byte(8'h41);
        b_step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) b_step(1, 4'hA, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("arst_crc", b_crc, 0);
        check("arst_flags", {b_busy, b_done, b_err, b_ser}, 0);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        b_feed_byte(8'h41);
        b_step(1, 4'hF, 1, 0, 0);
        check("start_en_crc", b_crc, 64'h58E558E558E558E5);
        check("start_en_busy", b_busy, 1);
        for (int i = 0; i < 16; i++) b_step(1, 0, 0, 0, 0);
        check("arst_out_done", b_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
